distribute_1xn_dst_tag_pipe: RTL
================================

# distribute_1xN_dst_tag_pipe

Registered, back-pressured 1-to-N distribute switch for the accelerator NoC distribution tree. It routes each input word to one of NUM_DATA_OUT outputs, or to all of them in broadcast mode, using the MSBs of the destination tag. The remaining tag bits are forwarded downstream. Each output has its own FIFO, so a stalled leaf blocks only traffic addressed to it. It is the pipelined, multi-way successor of the combinational 1x2 destination-tag distribute primitive and cascades into multi-level trees.

## Interface
- DATA_WIDTH, 32, payload width
- DESTINATION_TAG_WIDTH, 4, input tag width; must be >= SEL_WIDTH
- NUM_DATA_OUT, 4, output count; power of two, >= 2
- FIFO_DEPTH, 4, entries per output FIFO; power of two, >= 2
- Derived (localparam): SEL_WIDTH = log2(NUM_DATA_OUT); OUT_TAG_WIDTH = DESTINATION_TAG_WIDTH-SEL_WIDTH, or 1 if that is 0

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_en  in  1  switch enable; gates acceptance only
- i_valid  in  1  input word valid
- i_data_bus  in  DATA_WIDTH  input payload
- i_cmd  in  DESTINATION_TAG_WIDTH  destination tag
- i_bcast  in  1  1 = deliver the word to every output
- o_ready  out  1  input accept (combinational)
- o_valid  out  NUM_DATA_OUT  per-output valid
- o_data_bus  out  NUM_DATA_OUT*DATA_WIDTH  output k on slice [k*DATA_WIDTH +: DATA_WIDTH]
- o_cmd  out  NUM_DATA_OUT*OUT_TAG_WIDTH  forwarded tag, output k on slice [k*OUT_TAG_WIDTH +: OUT_TAG_WIDTH]
- i_ready  in  NUM_DATA_OUT  per-output downstream ready
- o_full  out  NUM_DATA_OUT  per-output FIFO full flag

## Operation
- Selection: sel = i_cmd[DESTINATION_TAG_WIDTH-1 -: SEL_WIDTH].
- Forwarded tag: fwd = i_cmd[OUT_TAG_WIDTH-1:0]. When DESTINATION_TAG_WIDTH == SEL_WIDTH, fwd = 1'b0.
- Ready rule:
  - Unicast: o_ready = i_en & ~full[sel].
  - Broadcast: o_ready = i_en & ~|full.
  - o_ready depends combinationally on i_cmd and i_bcast. It does not depend on i_valid or i_ready, so there is no combinational path from i_ready to o_ready.
- Accept = i_valid & o_ready.
  - Unicast: {fwd, i_data_bus} is written to FIFO[sel].
  - Broadcast: the same pair is written to all FIFOs in the same cycle. All-or-nothing; there are no partial broadcasts.
- Output k: o_valid[k] = ~empty[k]. o_data_bus and o_cmd slices show the FIFO head. Pop occurs when o_valid[k] & i_ready[k].
- Dummy data: while o_valid[k] = 0, the data and cmd slices are driven to 0, never x or z.
- i_en = 0: no accepts (o_ready = 0). FIFOs keep draining and no stored data is lost.
- Each FIFO holds a pointer pair plus a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH)
  - empty = (count == 0)

## Timing
- Reset (rst high at a clk edge): all counts and pointers go to 0.
  - o_valid = 0, o_full = 0, o_data_bus = 0, o_cmd = 0.
  - o_ready = 0 while rst is high.
  - A reset in mid-operation discards all buffered words.
- Latency: a word accepted at edge N is visible at its output(s) after edge N, so o_valid rises 1 cycle after acceptance.
- Throughput: 1 word/cycle into any non-full output. Each output sustains 1 word/cycle when i_ready is held high.
- Simultaneous push and pop on the same FIFO:
  - Not full: count is unchanged and the head advances.
  - Full: no push, because o_ready is based on full only. There is no pass-through.
  - Empty: the word is written; o_valid rises next cycle.
- A word stays on its output, with stable data and cmd, until i_ready[k] is seen high. Downstream may rely on this.
- Ordering: per-output FIFO order equals input acceptance order. There is no ordering guarantee across outputs.

## Structure
- The shared package noc_pkg holds:
  - a log2 constant function
  - the OUT_TAG_WIDTH derivation
  - width checks that produce an elaboration error on an illegal NUM_DATA_OUT, FIFO_DEPTH or DESTINATION_TAG_WIDTH
- Sub-module sync_fifo_fwft (WIDTH, DEPTH): synchronous first-word-fall-through FIFO with count, full and empty.
  - Instantiated NUM_DATA_OUT times with WIDTH = DATA_WIDTH + OUT_TAG_WIDTH.
- Top level holds only the sel/fwd decode, the ready and write-enable fan-out, and output zeroing.

## Test plan
- Reset: assert rst 2 cycles while driving i_valid = 1 → o_valid = 0, o_data_bus = 0, o_cmd = 0, o_ready = 0. Deassert → o_ready = 1 when i_en = 1.
- Unicast routing, defaults: i_cmd = 4'b10_11, data 0xA5A5A5A5 → next cycle only o_valid[2] = 1, slice 2 = 0xA5A5A5A5, o_cmd slice 2 = 2'b11. Repeat for sel 0..3.
- Backpressure: hold i_ready[1] = 0 and push 5 words to sel 1 → 4 are accepted, then o_full[1] = 1 and o_ready = 0 for sel 1. Sel 3 still accepts. Release → words 1..4 drain in order, one per cycle.
- Broadcast: i_bcast = 1 with FIFO[0] full → o_ready = 0 and no FIFO is written. Drain one entry → word lands in all 4 FIFOs in the same cycle.
- Full + pop same cycle: FIFO[2] full, i_ready[2] = 1, push to sel 2 → rejected that cycle. Accepted the next cycle, with count back to 4.
- i_en and mid-reset: i_en = 0 with 3 words buffered → they still drain and no new accepts occur. Pulse rst with FIFOs partially full → all o_valid are 0 on the next cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC distribution helpers: constant log2, forwarded-tag width derivation
// and legality checks for distribute-switch parameters.
package noc_pkg;

    function automatic int log2c(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

    // Tag bits left after the selector is stripped; a zero-width tag becomes one tied bit.
    function automatic int out_tag_width(input int tag_width, input int num_out);
        int w;
        w = tag_width - log2c(num_out);
        return (w <= 0) ? 1 : w;
    endfunction

    function automatic bit is_pow2_ge2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit dist_params_ok(input int num_out, input int fifo_depth,
                                          input int tag_width);
        return is_pow2_ge2(num_out) && is_pow2_ge2(fifo_depth) &&
               (tag_width >= log2c(num_out));
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible on rd_data
// whenever empty is low; rd_en pops it. Pushes while full and pops while empty are ignored.
module sync_fifo_fwft
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = log2c(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/distribute_1xn_dst_tag_pipe.sv
// Registered 1-to-N destination-tag distribute switch with one FWFT FIFO per output,
// optional broadcast, and zeroed output slices while an output has nothing to show.
module distribute_1xn_dst_tag_pipe
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int DESTINATION_TAG_WIDTH = 4,
    parameter int NUM_DATA_OUT          = 4,
    parameter int FIFO_DEPTH            = 4,
    localparam int SEL_WIDTH     = log2c(NUM_DATA_OUT),
    localparam int OUT_TAG_WIDTH = out_tag_width(DESTINATION_TAG_WIDTH, NUM_DATA_OUT)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_en,
    input  logic                                  i_valid,
    input  logic [DATA_WIDTH-1:0]                 i_data_bus,
    input  logic [DESTINATION_TAG_WIDTH-1:0]      i_cmd,
    input  logic                                  i_bcast,
    output logic                                  o_ready,
    output logic [NUM_DATA_OUT-1:0]               o_valid,
    output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]    o_data_bus,
    output logic [NUM_DATA_OUT*OUT_TAG_WIDTH-1:0] o_cmd,
    input  logic [NUM_DATA_OUT-1:0]               i_ready,
    output logic [NUM_DATA_OUT-1:0]               o_full
);

    localparam int ENTRY_W = DATA_WIDTH + OUT_TAG_WIDTH;

    if (!dist_params_ok(NUM_DATA_OUT, FIFO_DEPTH, DESTINATION_TAG_WIDTH)) begin : g_param_error
        $error("distribute_1xn_dst_tag_pipe: illegal NUM_DATA_OUT/FIFO_DEPTH/DESTINATION_TAG_WIDTH");
    end

    logic [SEL_WIDTH-1:0]     sel;
    logic [OUT_TAG_WIDTH-1:0] fwd;
    logic [NUM_DATA_OUT-1:0]  full;
    logic [NUM_DATA_OUT-1:0]  empty;
    logic [NUM_DATA_OUT-1:0]  wr_en;
    logic [NUM_DATA_OUT-1:0]  rd_en;
    logic                     accept;

    assign sel = i_cmd[DESTINATION_TAG_WIDTH-1 -: SEL_WIDTH];

    if (DESTINATION_TAG_WIDTH > SEL_WIDTH) begin : g_fwd_tag
        assign fwd = i_cmd[OUT_TAG_WIDTH-1:0];
    end else begin : g_fwd_zero
        assign fwd = '0;
    end

    // Handshake: input word moves when i_valid & o_ready; output k pops when
    // o_valid[k] & i_ready[k]. o_ready looks only at full flags, i_en, i_cmd,
    // i_bcast and rst, so i_ready never reaches o_ready combinationally.
    always_comb begin
        o_ready = 1'b0;
        if (!rst && i_en) begin
            o_ready = i_bcast ? ~|full : ~full[sel];
        end
    end

    assign accept = i_valid & o_ready;
    assign o_full = full;

    for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_out
        logic [ENTRY_W-1:0] head;

        assign wr_en[k] = accept & (i_bcast | (sel == SEL_WIDTH'(k)));
        assign rd_en[k] = i_ready[k] & ~empty[k];

        sync_fifo_fwft #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[k]),
            .wr_data ({fwd, i_data_bus}),
            .rd_en   (rd_en[k]),
            .rd_data (head),
            .full    (full[k]),
            .empty   (empty[k])
        );

        // Empty outputs present zeros rather than stale memory contents.
        assign o_valid[k] = ~empty[k];
        assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
            empty[k] ? '0 : head[DATA_WIDTH-1:0];
        assign o_cmd[k*OUT_TAG_WIDTH +: OUT_TAG_WIDTH] =
            empty[k] ? '0 : head[ENTRY_W-1 -: OUT_TAG_WIDTH];
    end

endmodule
